// File: rtl/systolic_edge_feeder.sv
// systolic_edge_feeder: transmit side of the PE array left/up edge.
// Accepts one K-slice per valid/ready beat (ROWS weights, COLS pixels)
// and drives diagonally skewed, registered streams into the array.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   mode_in             0 = 8x8, 1 = 1x8; taken from the first beat
//   in_valid/in_ready   slice handshake; in_last marks final slice
//   in_weight/in_pixel  row r at [r*W_LEFT +: W_LEFT], col c likewise
//   left_out/up_out     skewed edge streams (row r / col c: r+1 / c+1 regs)
//   array_en/array_mode global PE enable and latched mode
//   done                one-cycle pulse once the last product is absorbed
//   beat_count          slices accepted in the current stream
// Optional: FEEDER_BUBBLE_STALL_EN makes STREAM bubbles stall the array
// (array_en low, delay lines frozen) instead of inserting zeros.

module systolic_edge_feeder #(
    parameter int ROWS    = 4,
    parameter int COLS    = 4,
    parameter int W_LEFT  = 8,
    parameter int W_UP    = 16,
    parameter int MAC_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mode_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_last,
    input  logic [ROWS*W_LEFT-1:0] in_weight,
    input  logic [COLS*W_UP-1:0]   in_pixel,
    output logic [ROWS*W_LEFT-1:0] left_out,
    output logic [COLS*W_UP-1:0]   up_out,
    output logic                   array_en,
    output logic                   array_mode,
    output logic                   done,
    output logic [CNT_W-1:0]       beat_count
);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH,
        DONE
    } state_t;

    // Zeros must travel through the longest skew path and the MAC pipe.
    localparam int FLUSH_LEN = ROWS + COLS - 1 + MAC_LAT;
    localparam int FW = $clog2(FLUSH_LEN + 1);

    state_t        state;
    logic [FW-1:0] fcnt;
    logic          en_q;
    logic          xfer;
    logic          shift_en;
    logic          shift;

    assign in_ready = (state == IDLE) || (state == STREAM);
    assign xfer     = in_valid && in_ready;

`ifdef FEEDER_BUBBLE_STALL_EN
    // A STREAM bubble freezes the whole array for that cycle.
    assign shift_en = en_q && !((state == STREAM) && !in_valid);
`else
    assign shift_en = en_q;
`endif

    assign array_en = shift_en;

    // The first beat is loaded on the IDLE edge, before array_en rises.
    assign shift = shift_en || ((state == IDLE) && xfer);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            fcnt       <= '0;
            en_q       <= 1'b0;
            done       <= 1'b0;
            array_mode <= 1'b0;
            beat_count <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (xfer) begin
                        array_mode <= mode_in;
                        beat_count <= CNT_W'(1);
                        en_q       <= 1'b1;
                        if (in_last) begin
                            state <= FLUSH;
                            fcnt  <= FW'(FLUSH_LEN - 1);
                        end else begin
                            state <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        if (beat_count != '1)
                            beat_count <= beat_count + 1'b1;
                        if (in_last) begin
                            state <= FLUSH;
                            fcnt  <= FW'(FLUSH_LEN - 1);
                        end
                    end
                end
                FLUSH: begin
                    if (fcnt == '0) begin
                        state <= DONE;
                        en_q  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        fcnt <= fcnt - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [W_LEFT-1:0] sr [r+1];
        logic [W_LEFT-1:0] ld;

        assign ld = xfer ? in_weight[r*W_LEFT +: W_LEFT] : '0;
        assign left_out[r*W_LEFT +: W_LEFT] = sr[r];

        always_ff @(posedge clk) begin
            if (reset) begin
                sr <= '{default: '0};
            end else if (shift) begin
                sr[0] <= ld;
                for (int k = 1; k <= r; k++)
                    sr[k] <= sr[k-1];
            end
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col
        logic [W_UP-1:0] sr [c+1];
        logic [W_UP-1:0] ld;

        assign ld = xfer ? in_pixel[c*W_UP +: W_UP] : '0;
        assign up_out[c*W_UP +: W_UP] = sr[c];

        always_ff @(posedge clk) begin
            if (reset) begin
                sr <= '{default: '0};
            end else if (shift) begin
                sr[0] <= ld;
                for (int k = 1; k <= c; k++)
                    sr[k] <= sr[k-1];
            end
        end
    end

endmodule

// File: tb/tb_systolic_edge_feeder.sv
// Bench for systolic_edge_feeder (default build): stimulus pushes
// expected per-cycle edge state into a queue; a monitor checks it.

module tb_systolic_edge_feeder;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int WL   = 8;
    localparam int WU   = 16;
    localparam int ML   = 2;
    localparam int CW   = 16;
    localparam int FL   = ROWS + COLS - 1 + ML;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 mode_in;
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_last;
    logic [ROWS*WL-1:0]   in_weight;
    logic [COLS*WU-1:0]   in_pixel;
    logic [ROWS*WL-1:0]   left_out;
    logic [COLS*WU-1:0]   up_out;
    logic                 array_en;
    logic                 array_mode;
    logic                 done;
    logic [CW-1:0]        beat_count;

    systolic_edge_feeder #(
        .ROWS(ROWS), .COLS(COLS), .W_LEFT(WL),
        .W_UP(WU), .MAC_LAT(ML), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .mode_in(mode_in),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .in_weight(in_weight),
        .in_pixel(in_pixel), .left_out(left_out),
        .up_out(up_out), .array_en(array_en),
        .array_mode(array_mode), .done(done),
        .beat_count(beat_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ROWS*WL-1:0] l;
        logic [COLS*WU-1:0] u;
        logic               en;
        logic               dn;
        logic               rdy;
        logic               md;
        logic [CW-1:0]      cnt;
    } rec_t;

    rec_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Model: a stream is a list of slots 1..L, one per cycle after
    // the first accept; a slot holds a beat or a bubble (zeros).
    int                 L;
    bit                 pv [64];
    logic [ROWS*WL-1:0] pw [64];
    logic [COLS*WU-1:0] pp [64];
    logic               pmode;
    logic [CW-1:0]      m_cnt;
    logic               m_md;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    rec_t mr;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            mr = q.pop_front();
            chk("left_out", 64'(left_out), 64'(mr.l));
            chk("up_out", 64'(up_out), 64'(mr.u));
            chk("array_en", 64'(array_en), 64'(mr.en));
            chk("done", 64'(done), 64'(mr.dn));
            chk("in_ready", 64'(in_ready), 64'(mr.rdy));
            chk("array_mode", 64'(array_mode), 64'(mr.md));
            chk("beat_count", 64'(beat_count), 64'(mr.cnt));
        end
    end

    function automatic rec_t idle_rec();
        rec_t r;
        r.l = '0; r.u = '0; r.en = 0; r.dn = 0;
        r.rdy = 1; r.md = m_md; r.cnt = m_cnt;
        return r;
    endfunction

    // Expected outputs s cycles after the first-beat cycle (s = 0).
    function automatic rec_t model(int s);
        rec_t r;
        int   j;
        int   n;
        r = idle_rec();
        if (s == 0) return r;
        r.en  = (s <= L + FL - 1);
        r.dn  = (s == L + FL);
        r.rdy = (s < L);
        r.md  = pmode;
        n = 0;
        for (int k = 1; k <= L && k <= s; k++)
            if (pv[k]) n++;
        r.cnt = CW'(n);
        for (int i = 0; i < ROWS; i++) begin
            j = s - i;
            if (r.en && j >= 1 && j <= L && pv[j])
                r.l[i*WL +: WL] = pw[j][i*WL +: WL];
        end
        for (int i = 0; i < COLS; i++) begin
            j = s - i;
            if (r.en && j >= 1 && j <= L && pv[j])
                r.u[i*WU +: WU] = pp[j][i*WU +: WU];
        end
        return r;
    endfunction

    task automatic junk();
        in_weight = {$urandom, $urandom} > 0 ? ROWS*WL'($urandom) : '0;
        in_pixel  = {$urandom, $urandom};
        in_last   = 1'($urandom);
        mode_in   = 1'($urandom);
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk); #1;
            reset    = 0;
            in_valid = 0;
            junk();
            q.push_back(idle_rec());
        end
    endtask

    // abort_s >= 0 asserts reset during that cycle of the stream.
    task automatic run_stream(int abort_s);
        int n;
        for (int s = 0; s <= L + FL; s++) begin
            @(posedge clk); #1;
            junk();
            if (s < L) begin
                in_valid = pv[s+1];
                in_last  = (s + 1 == L);
                if (pv[s+1]) begin
                    in_weight = pw[s+1];
                    in_pixel  = pp[s+1];
                end
                if (s == 0) mode_in = pmode;
            end else begin
                in_valid = 1'($urandom);
            end
            reset = (s == abort_s);
            q.push_back(model(s));
            if (s == abort_s) begin
                m_cnt = '0;
                m_md  = 1'b0;
                return;
            end
        end
        n = 0;
        for (int k = 1; k <= L; k++)
            if (pv[k]) n++;
        m_cnt = CW'(n);
        m_md  = pmode;
    endtask

    task automatic rand_plan(int len);
        L = len;
        pmode = 1'($urandom);
        for (int j = 1; j <= L; j++) begin
            pv[j] = (j == 1 || j == L) ? 1'b1 : ($urandom_range(0, 2) != 0);
            pw[j] = ROWS*WL'($urandom);
            pp[j] = {$urandom, $urandom};
        end
    endtask

    initial begin
        reset = 1; in_valid = 0; in_last = 0; mode_in = 0;
        in_weight = '0; in_pixel = '0;
        m_cnt = '0; m_md = 1'b0;
        repeat (3) @(posedge clk);
        idle(2);

        // single beat from the worked example
        L = 1; pmode = 0; pv[1] = 1;
        pw[1] = {8'd4, 8'd3, 8'd2, 8'd1};
        pp[1] = {16'd40, 16'd30, 16'd20, 16'd10};
        run_stream(-1);
        idle(1);

        // three-beat continuous stream, back-to-back with next
        L = 3; pmode = 0;
        for (int j = 1; j <= 3; j++) begin
            pv[j] = 1;
            pw[j] = {4{8'(j)}};
            pp[j] = {4{16'(j * 100)}};
        end
        run_stream(-1);

        // bubble between two beats
        L = 3; pmode = 0;
        pv[1] = 1; pv[2] = 0; pv[3] = 1;
        pw[1] = {4{8'h11}}; pw[3] = {4{8'h33}};
        pp[1] = {4{16'h0101}}; pp[3] = {4{16'h0303}};
        run_stream(-1);
        idle(1);

        // reset in the middle of FLUSH, then a clean single beat
        rand_plan(2);
        run_stream(5);
        idle(2);
        L = 1; pmode = 0; pv[1] = 1;
        pw[1] = {8'd4, 8'd3, 8'd2, 8'd1};
        pp[1] = {16'd40, 16'd30, 16'd20, 16'd10};
        run_stream(-1);
        idle(1);

        // mode latched from the first beat only
        L = 4; pmode = 1;
        for (int j = 1; j <= 4; j++) begin
            pv[j] = 1;
            pw[j] = ROWS*WL'($urandom);
            pp[j] = {$urandom, $urandom};
        end
        run_stream(-1);

        // randomized streams with random gaps (0 = back-to-back)
        for (int t = 0; t < 25; t++) begin
            rand_plan($urandom_range(1, 7));
            run_stream(-1);
            idle($urandom_range(0, 2));
        end

        idle(2);
        @(negedge clk); #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover: got %0d want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/systolic_edge_feeder.md
Name: systolic_edge_feeder

Overview:
- Transmit side of the PE array's left/up systolic interface.
- Accepts one K-slice per beat over a valid/ready handshake: ROWS weights and COLS pixels.
- Drives the array's left and top edges with diagonally skewed, registered streams, plus the global array enable and mode.
- After the last slice, flushes zeros until the bottom-right PE's MAC has absorbed the final product, then pulses done.

Parameters:
- ROWS, 4, PE rows; row r drives that row's 8-bit left input.
- COLS, 4, PE columns; column c drives that column's 16-bit up input.
- W_LEFT, 8, weight width per row.
- W_UP, 16, pixel width per column.
- MAC_LAT, 2, MAC pipeline depth in enabled cycles.
- CNT_W, 16, beat counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- mode_in  in  1  0 = 8x8 mode, 1 = 1x8 mode; sampled on the first accepted beat.
- in_valid  in  1  slice valid.
- in_ready  out  1  feeder accepts a slice.
- in_last  in  1  final slice of the stream.
- in_weight  in  ROWS*W_LEFT  row r at bits [r*W_LEFT +: W_LEFT].
- in_pixel  in  COLS*W_UP  column c at bits [c*W_UP +: W_UP].
- left_out  out  ROWS*W_LEFT  skewed weights to the array's left edge.
- up_out  out  COLS*W_UP  skewed pixels to the array's top edge.
- array_en  out  1  global PE/MAC enable.
- array_mode  out  1  latched mode.
- done  out  1  one-cycle pulse when the array result is final.
- beat_count  out  CNT_W  slices accepted in the current stream.

Behaviour:
- Reset (synchronous, active-high, clk): clears all outputs, skew registers, counters and state to 0; state goes to IDLE. A reset mid-stream or mid-flush aborts with no done pulse.
- Handshake: a beat transfers when in_valid && in_ready at a rising edge.
  - in_ready = 1 in IDLE and STREAM, 0 in FLUSH and DONE.
- IDLE:
  - array_en = 0, edge outputs are 0.
  - On a transfer: latch array_mode <= mode_in, beat_count <= 1, load the beat into the skew stage. Go to FLUSH if in_last, else STREAM.
- STREAM:
  - array_en = 1 every cycle.
  - Transfer: load the beat and increment beat_count (saturating at all-ones). Go to FLUSH if in_last.
  - No transfer (bubble): load zeros into the skew stage. Zero-pairs add nothing to the MAC.
  - mode_in is ignored until the next IDLE.
- FLUSH:
  - array_en = 1; zeros are loaded.
  - Lasts FLUSH_LEN = ROWS+COLS-1+MAC_LAT cycles (9 at defaults), counted by a down-counter. Then go to DONE.
- DONE: done = 1 and array_en = 0 for one cycle, then IDLE. beat_count holds until the next first beat.
- Skew and timing:
  - Row r is a registered delay line of r+1 stages; column c has c+1 stages.
  - A beat accepted at edge t appears on left_out row r during cycle t+1+r and on up_out column c during cycle t+1+c.
  - Delay lines shift only while array_en = 1 (or on the IDLE transfer edge). All edge outputs are registered; there is no combinational input-to-output path.
- Back-to-back streams: a new stream may be accepted in the IDLE cycle after DONE.

Optional Feature:
- FEEDER_BUBBLE_STALL_EN
  - Defined: a bubble in STREAM drives array_en = 0 and freezes all delay lines, so the array stalls instead of receiving zeros. FLUSH is unchanged.
  - Undefined: bubbles insert zeros with array_en = 1 (default behaviour above).

Test Plan:
- Single beat: mode_in=0, in_weight={4,3,2,1} (row0=1), in_pixel={40,30,20,10}, in_last=1 at edge t.
  - left_out row0=1 at t+1 and row3=4 at t+4; up_out col2=30 at t+3; zeros elsewhere.
  - array_en high t+1..t+9; done high at t+10 only; beat_count=1.
- Three-beat continuous stream of weights 1,2,3 on all rows.
  - Row 0 sees 1,2,3 at t+1..t+3; row 2 sees them at t+3..t+5.
  - in_ready low from t+3 until IDLE; beat_count=3.
- Bubble, macro undefined: beats at t and t+2, in_valid low at t+1.
  - Row0 shows v0,0,v1 over t+1..t+3; array_en continuously high.
- Bubble, FEEDER_BUBBLE_STALL_EN defined: same stimulus.
  - array_en low during cycle t+1; outputs hold their t+1 values; done is one cycle later than the undefined case.
- Reset asserted mid-FLUSH: next cycle all outputs are 0, state IDLE, no done; a subsequent stream behaves like the single-beat case.
- Mode latching: mode_in=1 on the first beat, then 0 on later beats → array_mode stays 1 until DONE completes.
